dreg_arbiter: RTL

DREG_ARBITER -- requirements
Module: dreg_arbiter

---
 rtl/dreg_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dreg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared data register, 4-phase req/gnt handshake.
// Optional WAIT_DROP timeout (to_err port) enabled by defining DREG_ARBITER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no owner; arbitrate any pending req from ptr upward
// GRANT     | one cycle; winner's wdata slice commits to q at exit
// WAIT_DROP | gnt held until winner drops req (or timeout when enabled)
module dreg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic               busy
`ifdef DREG_ARBITER_TIMEOUT_EN
  ,
  output logic               to_err
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [3:0]       elig;
  logic [1:0]       win_sel;
  logic [1:0]       idx;
  logic             found;

`ifdef DREG_ARBITER_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       to_err_q, to_err_d;
  logic [3:0] blk_q, blk_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
`ifdef DREG_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_err_d  = to_err_q;
    // a timed-out requester stays masked until its req is seen low
    blk_d     = blk_q & req;
    elig      = req & ~blk_q;
`else
    elig      = req;
`endif

    found   = 1'b0;
    win_sel = ptr_q;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_sel = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_sel;
          win_d   = win_sel;
          ptr_d   = win_sel + 2'd1;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        q_d       = wdata[32'(win_q) * WIDTH +: WIDTH];
        q_valid_d = 1'b1;
        state_d   = WAIT_DROP;
`ifdef DREG_ARBITER_TIMEOUT_EN
        cnt_d     = 4'd0;
`endif
      end
      WAIT_DROP: begin
        if (!req[win_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
`ifdef DREG_ARBITER_TIMEOUT_EN
        // cnt_q==14 marks the 15th WAIT_DROP cycle
        else if (cnt_q == 4'd14) begin
          state_d       = IDLE;
          gnt_d         = 4'b0000;
          to_err_d      = 1'b1;
          blk_d[win_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
`ifdef DREG_ARBITER_TIMEOUT_EN
      cnt_q     <= 4'd0;
      to_err_q  <= 1'b0;
      blk_q     <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
`ifdef DREG_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_err_q  <= to_err_d;
      blk_q     <= blk_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q != IDLE);
`ifdef DREG_ARBITER_TIMEOUT_EN
  assign to_err  = to_err_q;
`endif

endmodule
